// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit (SLL, SRL, SRA, ROTR).
// A request is taken over a valid/ready handshake. The unit moves the
// operand by at most STEP bits per clock and presents the result, together
// with the last bit shifted/rotated out, until the consumer takes it.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   in_valid/in_ready request handshake; in_ready only in IDLE
//   in_data           operand
//   in_shamt          shift amount, 0..DATA_BUS_WIDTH-1
//   in_op             00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   out_valid/ready   result handshake; out_valid only in DONE
//   out_data          result (0 outside DONE)
//   out_shift_bit     last bit out, 0 when shamt=0 (0 outside DONE)
//   busy              high while an operation is in flight (SHIFT/DONE)
module seq_shift_unit #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int STEP           = 4,
  localparam int SHAMT_W       = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_BUS_WIDTH-1:0] in_data,
  input  logic [SHAMT_W-1:0]        in_shamt,
  input  logic [1:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_BUS_WIDTH-1:0] out_data,
  output logic                      out_shift_bit,
  output logic                      busy
);
  localparam int W = DATA_BUS_WIDTH;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  // One extra bit so STEP == DATA_BUS_WIDTH is representable.
  localparam logic [SHAMT_W:0] STEP_V = (SHAMT_W+1)'(STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state, state_nx;
  logic [W-1:0]       data_r, data_nx;
  logic [SHAMT_W-1:0] rem_r, rem_nx;
  logic [1:0]         op_r, op_nx;
  logic               sbit_r, sbit_nx;

  // Step datapath: sources are the request in IDLE, the registers otherwise.
  logic [W-1:0]       src_d, sh_d, lsh, rsh;
  logic [2*W-1:0]     rot;
  logic [SHAMT_W-1:0] src_amt, k, km1, rem_left;
  logic [1:0]         src_op;
  logic               sh_b;

  always_comb begin
    src_d   = (state == S_IDLE) ? in_data  : data_r;
    src_amt = (state == S_IDLE) ? in_shamt : rem_r;
    src_op  = (state == S_IDLE) ? in_op    : op_r;
    // k = min(amount, STEP); with STEP == W the amount always wins.
    k        = ({1'b0, src_amt} < STEP_V) ? src_amt : STEP_V[SHAMT_W-1:0];
    km1      = k - SHAMT_W'(1);
    rem_left = src_amt - k;
    // Shifting by k-1 leaves the last bit that leaves the word at the edge.
    lsh = src_d << km1;
    rsh = src_d >> km1;
    rot = {src_d, src_d} >> k;
    case (src_op)
      OP_SLL: begin sh_d = src_d << k; sh_b = lsh[W-1]; end
      OP_SRL: begin sh_d = src_d >> k; sh_b = rsh[0];   end
      // Arithmetic shift of the partially shifted word keeps the sign.
      OP_SRA: begin sh_d = $unsigned($signed(src_d) >>> k); sh_b = rsh[0]; end
      default: begin sh_d = rot[W-1:0]; sh_b = rsh[0]; end
    endcase
    if (k == '0) sh_b = 1'b0;
  end

  always_comb begin
    state_nx = state;
    data_nx  = data_r;
    rem_nx   = rem_r;
    op_nx    = op_r;
    sbit_nx  = sbit_r;
    case (state)
      S_IDLE: if (in_valid) begin
        data_nx  = sh_d;
        rem_nx   = rem_left;
        op_nx    = in_op;
        sbit_nx  = sh_b;
        state_nx = (rem_left == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        data_nx = sh_d;
        rem_nx  = rem_left;
        sbit_nx = sh_b;
        if (rem_left == '0) state_nx = S_DONE;
      end
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      data_r <= '0;
      rem_r  <= '0;
      op_r   <= '0;
      sbit_r <= 1'b0;
    end else begin
      state  <= state_nx;
      data_r <= data_nx;
      rem_r  <= rem_nx;
      op_r   <= op_nx;
      sbit_r <= sbit_nx;
    end
  end

  // Result outputs are gated so partial shifts are never visible.
  assign in_ready      = (state == S_IDLE);
  assign out_valid     = (state == S_DONE);
  assign busy          = (state != S_IDLE);
  assign out_data      = out_valid ? data_r : '0;
  assign out_shift_bit = out_valid & sbit_r;
endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit at STEP = 1, 4 and 32. Each
// instance has its own driver, expected-result queue and monitor; the
// expected results come from a one-shot reference model of the shift rules.
module tb_seq_shift_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ndone = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    int           lat;
    int           acc;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=0x%0h req=0x%0h", nm, act, req);
    end
  endtask

  // Whole-word reference: {last bit out, result}.
  function automatic logic [W:0] ref_shift(input logic [W-1:0] d, input int sh,
                                           input logic [1:0] op);
    logic [W-1:0]   r;
    logic [2*W-1:0] dd;
    logic           b;
    dd = {d, d} >> sh;
    case (op)
      2'd0:    r = d << sh;
      2'd1:    r = d >> sh;
      2'd2:    r = $unsigned($signed(d) >>> sh);
      default: r = dd[W-1:0];
    endcase
    b = 1'b0;
    if (sh != 0) b = (op == 2'd0) ? d[W-sh] : d[sh-1];
    return {b, r};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int ST = (gi == 0) ? 1 : (gi == 1) ? 4 : 32;

    logic         rst_n, in_valid, in_ready, out_valid, out_ready, out_shift_bit, busy;
    logic [W-1:0] in_data, out_data;
    logic [4:0]   in_shamt;
    logic [1:0]   in_op;
    exp_t         q[$];
    exp_t         e;
    bit           seen = 1'b0;

    seq_shift_unit #(.DATA_BUS_WIDTH(W), .STEP(ST)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_shift_bit(out_shift_bit), .busy(busy)
    );

    function automatic int lat_of(input int sh);
      return (sh == 0) ? 1 : (sh + ST - 1) / ST;
    endfunction

    // Monitor: compare each result on the cycle out_valid first rises.
    always @(negedge clk) begin
      if (!out_valid) seen <= 1'b0;
      else if (!seen) begin
        seen <= 1'b1;
        chk($sformatf("st%0d result expected", ST), 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk($sformatf("st%0d data", ST), out_data, e.d);
          chk($sformatf("st%0d shift_bit", ST), 32'(out_shift_bit), 32'(e.b));
          chk($sformatf("st%0d latency", ST), 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end

    // Present a request, wait for accept, then record the expectation.
    task automatic issue(input logic [W-1:0] d, input int sh, input logic [1:0] op,
                         input logic [W-1:0] ed, input logic eb);
      int n = 0;
      in_data = d; in_shamt = 5'(sh); in_op = op; in_valid = 1'b1;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      chk($sformatf("st%0d accept ready", ST), 32'(in_ready), 1);
      @(posedge clk); #1;
      q.push_back('{d: ed, b: eb, lat: lat_of(sh), acc: cyc});
      in_valid = 1'b0;
      // Scramble inputs: they must only matter at accept.
      in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
    endtask

    task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      chk($sformatf("st%0d idle", ST), 32'(in_ready), 1);
    endtask

    initial begin
      logic [W:0] r;
      int bc;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_shamt = '0; in_op = '0;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("st%0d rst in_ready", ST), 32'(in_ready), 1);
      chk($sformatf("st%0d rst out_valid", ST), 32'(out_valid), 0);
      chk($sformatf("st%0d rst busy", ST), 32'(busy), 0);
      chk($sformatf("st%0d rst out_data", ST), out_data, 0);
      chk($sformatf("st%0d rst shift_bit", ST), 32'(out_shift_bit), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // SLL 1 by 31, counting busy cycles.
      issue(32'h1, 31, 2'd0, 32'h8000_0000, 1'b0);
      bc = 0;
      while (busy && bc < 100) begin bc++; @(posedge clk); #1; end
      chk($sformatf("st%0d sll31 busy cycles", ST), 32'(bc), 32'(lat_of(31)));

      issue(32'h8000_0000, 4, 2'd2, 32'hF800_0000, 1'b0);
      issue(32'hFFFF_FFFF, 13, 2'd1, 32'h0007_FFFF, 1'b1);
      issue(32'h0000_000F, 4, 2'd3, 32'hF000_0000, 1'b1);
      issue(32'h1234_5678, 0, 2'd3, 32'h1234_5678, 1'b0);
      wait_idle();

      // Backpressure with a competing request held on the input.
      out_ready = 1'b0;
      issue(32'h3, 5, 2'd0, 32'h60, 1'b0);
      bc = 0;
      while (!out_valid && bc < 100) begin bc++; @(posedge clk); #1; end
      in_data = 32'hF0; in_shamt = 5'd4; in_op = 2'd1; in_valid = 1'b1;
      repeat (5) begin
        @(posedge clk); #1;
        chk($sformatf("st%0d bp out_valid", ST), 32'(out_valid), 1);
        chk($sformatf("st%0d bp out_data", ST), out_data, 32'h60);
        chk($sformatf("st%0d bp in_ready", ST), 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("st%0d bp exit in_ready", ST), 32'(in_ready), 1);
      chk($sformatf("st%0d bp exit out_valid", ST), 32'(out_valid), 0);
      @(posedge clk); #1;
      chk($sformatf("st%0d bp held accepted", ST), 32'(in_ready), 0);
      q.push_back('{d: 32'hF, b: 1'b0, lat: lat_of(4), acc: cyc});
      in_valid = 1'b0;
      wait_idle();

      // Async reset partway through SLL by 31.
      out_ready = 1'b0;
      issue(32'h1, 31, 2'd0, 32'h8000_0000, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      chk($sformatf("st%0d pre-rst busy", ST), 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk($sformatf("st%0d arst out_valid", ST), 32'(out_valid), 0);
      chk($sformatf("st%0d arst busy", ST), 32'(busy), 0);
      chk($sformatf("st%0d arst out_data", ST), out_data, 0);
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("st%0d post-rst in_ready", ST), 32'(in_ready), 1);
      issue(32'h100, 8, 2'd1, 32'h1, 1'b0);

      // Sweep all ops and amounts with random operands.
      for (int op = 0; op < 4; op++)
        for (int sh = 0; sh < W; sh++) begin
          logic [W-1:0] d;
          d = $urandom;
          r = ref_shift(d, sh, 2'(op));
          issue(d, sh, 2'(op), r[W-1:0], r[W]);
        end
      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("st%0d queue drained", ST), 32'(q.size()), 0);
      ndone++;
    end
  end

  initial begin
    int t = 0;
    while (ndone < 3 && t < 80000) begin @(posedge clk); t++; end
    if (ndone < 3) chk("drivers finished", 32'(ndone), 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Parametrised multi-cycle shift/rotate unit and successor to the fixed combinational shift-by-2 blocks. It takes an operand, a shift amount and an op code over a valid/ready handshake. It shifts by at most STEP bits per clock and returns the result plus the last bit shifted out. It sits beside the ALU in the execute stage for variable shifts (SLL/SRL/SRA/ROTR); the stall logic holds the pipeline while busy is high.

Parameters:
DATA_BUS_WIDTH, 32, operand/result width; power of 2, at least 4.
STEP, 4, maximum bits shifted per clock; power of 2, 1 to DATA_BUS_WIDTH.
SHAMT_W (localparam), clog2(DATA_BUS_WIDTH), shift amount width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  request present.
in_ready  out  1  unit can accept a request.
in_data  in  DATA_BUS_WIDTH  operand.
in_shamt  in  SHAMT_W  shift amount, 0 to DATA_BUS_WIDTH-1.
in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR (rotate right).
out_valid  out  1  result available.
out_ready  in  1  consumer takes the result.
out_data  out  DATA_BUS_WIDTH  result.
out_shift_bit  out  1  last bit shifted/rotated out; 0 when shamt=0.
busy  out  1  high in SHIFT or DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE; out_valid=0, out_data=0, out_shift_bit=0, busy=0, in_ready=1; all internal registers cleared.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). Accept happens on a rising edge with in_valid && in_ready.
- At accept:
  - Latch op.
  - Apply the first step: k = min(shamt, STEP).
  - data_reg = in_data shifted by k; rem = shamt - k; sbit = last bit out (0 if k=0).
  - Next state: DONE if rem==0, else SHIFT.
- SHIFT, each edge: k = min(rem, STEP); data_reg shifted by k; rem -= k; sbit updated. Go to DONE when the new rem==0.
- Latency: out_valid rises max(1, ceil(shamt/STEP)) clocks after the accept edge. Examples at 32/4: shamt 0 or 1..4 → 1; shamt 31 → 8.
- Shift rules:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with operand MSB; the sign is held across steps.
  - ROTR wraps LSBs into MSBs.
- Final out_shift_bit:
  - SLL: in_data[W-shamt].
  - SRL, SRA, ROTR: in_data[shamt-1].
- DONE: out_valid=1; out_data and out_shift_bit are driven from registers and held stable while out_ready=0.
- DONE exit: on an edge with out_ready=1, go to IDLE and drop out_valid. in_ready rises the following cycle. There is no accept in the handshake cycle, so there is one bubble between results by design.
- in_valid in SHIFT or DONE is ignored; there is no queueing.
- out_valid is never high outside DONE.
- in_data, in_shamt and in_op are sampled only at accept, so input changes afterwards have no effect.
- Async reset mid-SHIFT or mid-DONE aborts the operation immediately: out_valid falls without waiting for a clock edge, and the result is discarded.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Test Plan:
- SLL 0x00000001 by 31 (W=32, STEP=4) → out_valid 8 clocks after accept; out_data=0x80000000; out_shift_bit=0; busy high for 8 cycles.
- SRA 0x80000000 by 4 → latency 1; out_data=0xF8000000; out_shift_bit=0. SRL 0xFFFFFFFF by 13 → latency 4; out_data=0x0007FFFF; out_shift_bit=1.
- ROTR 0x0000000F by 4 → out_data=0xF0000000, out_shift_bit=1. ROTR 0x12345678 by 0 → latency 1; out_data=0x12345678; out_shift_bit=0.
- Backpressure: result ready with out_ready=0 for 5 cycles.
  - Required: out_data and out_valid stable, in_ready=0, and a held new in_valid is ignored.
  - Then out_ready=1: IDLE next edge; the new request is accepted the following edge.
- Reset: assert rst_n=0 in the 3rd SHIFT cycle of SLL by 31.
  - Required: out_valid, busy and out_data go to 0 asynchronously, and in_ready=1 after release.
  - Then SRL 0x100 by 8 → 0x00000001.
- Sweep: random operands and all shamt 0..31 × 4 ops, at STEP ∈ {1, 4, 32}.
  - Required: results match the reference model, and latency equals max(1, ceil(shamt/STEP)).
